// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants, slice sizing and stage payload type for pipelined_adder
package adder_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;

  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

  // Stage payload at the default geometry; the top sizes each field per stage.
  typedef struct packed {
    logic                     valid;
    logic [DEFAULT_WIDTH-1:0] psum;
    logic [DEFAULT_WIDTH-1:0] a_rem;
    logic [DEFAULT_WIDTH-1:0] b_rem;
    logic                     carry;
  } stage_payload_t;

endpackage

// File: rtl/adder_slice.sv
// rtl/adder_slice.sv - combinational W-bit ripple chain of full-adder cells
module adder_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W:0] carry;

  always_comb begin
    carry    = '0;
    sum_o    = '0;
    carry[0] = cin_i;
    for (int i = 0; i < W; i++) begin
      sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry[W];
  end

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - WIDTH-bit ripple-carry adder split into STAGES carry-registered slices
// Optional signed-overflow output ovf is enabled by defining PIPELINED_ADDER_OVF_EN.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPELINED_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int SLICE = slice_width(WIDTH, STAGES);

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
  end

  logic [STAGES-1:0] valid_vec;
  logic [STAGES-1:0] adv;
  logic [WIDTH-1:0]  sum_q;
  logic              cout_q;
`ifdef PIPELINED_ADDER_OVF_EN
  logic              ovf_q;
`endif

  // A stage stalls only when it and every stage ahead of it is full and the sink is not taking.
  always_comb begin : p_advance
    logic full_ahead;
    full_ahead = 1'b1;
    adv        = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      full_ahead = full_ahead & valid_vec[k];
      adv[k]     = !full_ahead || out_ready;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SLICE;
    localparam int HI = WIDTH - LO;

    logic               src_valid;
    logic [HI-1:0]      src_a;
    logic [HI-1:0]      src_b;
    logic               src_c;
    logic [SLICE-1:0]   slice_sum;
    logic               slice_cout;
    logic [LO+SLICE-1:0] done_d;
    logic               valid_q;

    if (k == 0) begin : g_from_in
      assign src_valid = in_valid;
      assign src_a     = a;
      assign src_b     = b;
      assign src_c     = cin;
      assign done_d    = slice_sum;
    end else begin : g_from_pipe
      assign src_valid = g_stage[k-1].valid_q;
      assign src_a     = g_stage[k-1].g_mid.a_q;
      assign src_b     = g_stage[k-1].g_mid.b_q;
      assign src_c     = g_stage[k-1].g_mid.carry_q;
      assign done_d    = {slice_sum, g_stage[k-1].g_mid.psum_q};
    end

    adder_slice #(.W(SLICE)) u_slice (
      .a_i    (src_a[SLICE-1:0]),
      .b_i    (src_b[SLICE-1:0]),
      .cin_i  (src_c),
      .sum_o  (slice_sum),
      .cout_o (slice_cout)
    );

    assign valid_vec[k] = valid_q;

    // An empty stage is overwritten whenever it advances, which compresses bubbles.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
      end else if (adv[k]) begin
        valid_q <= src_valid;
      end
    end

    if (k < STAGES - 1) begin : g_mid
      logic [HI-SLICE-1:0] a_q;
      logic [HI-SLICE-1:0] b_q;
      logic [LO+SLICE-1:0] psum_q;
      logic                carry_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q     <= '0;
          b_q     <= '0;
          psum_q  <= '0;
          carry_q <= 1'b0;
        end else if (adv[k] && src_valid) begin
          a_q     <= src_a[HI-1:SLICE];
          b_q     <= src_b[HI-1:SLICE];
          psum_q  <= done_d;
          carry_q <= slice_cout;
        end
      end
    end else begin : g_last
      always_ff @(posedge clk) begin
        if (rst) begin
          sum_q  <= '0;
          cout_q <= 1'b0;
`ifdef PIPELINED_ADDER_OVF_EN
          ovf_q  <= 1'b0;
`endif
        end else if (adv[k] && src_valid) begin
          sum_q  <= done_d;
          cout_q <= slice_cout;
`ifdef PIPELINED_ADDER_OVF_EN
          // a^b^sum at the MSB recovers the carry into the MSB.
          ovf_q  <= src_a[SLICE-1] ^ src_b[SLICE-1] ^ slice_sum[SLICE-1] ^ slice_cout;
`endif
        end
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = valid_vec[STAGES-1];
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef PIPELINED_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - directed self-checking bench for pipelined_adder (WIDTH=32, STAGES=4)
module tb_pipelined_adder;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef PIPELINED_ADDER_OVF_EN
  logic         ovf;
`endif

  int n_assert;
  int n_fail;

  logic [W-1:0] va [8];
  logic [W-1:0] vb [8];
  logic         vc [8];
  logic [W-1:0] es [8];
  logic         ec [8];

  pipelined_adder #(.WIDTH(W), .STAGES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_beat(input int i);
    in_valid = (i < 8);
    if (i < 8) begin
      a   = va[i];
      b   = vb[i];
      cin = vc[i];
    end
  endtask

  task automatic single(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic [W-1:0] exp_s, input logic exp_c,
                        input logic exp_o);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = av;
    b         = bv;
    cin       = cv;
    #1;
    check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(4));
    check({tag, "_sum"}, 64'(sum), 64'(exp_s));
    check({tag, "_cout"}, 64'(cout), 64'(exp_c));
`ifdef PIPELINED_ADDER_OVF_EN
    check({tag, "_ovf"}, 64'(ovf), 64'(exp_o));
`else
    if (exp_o === 1'bx) lat = 0;
`endif
    @(negedge clk);
    check({tag, "_drained"}, 64'(out_valid), 64'(0));
  endtask

  initial begin
    int idx;
    int oidx;
    int stale;
    logic acc;
    logic [W-1:0] held;

    n_assert = 0;
    n_fail   = 0;
    va = '{32'h0000_0001, 32'h1234_5678, 32'hFFFF_FFFF, 32'h8000_0000,
           32'h0000_FFFF, 32'hAAAA_AAAA, 32'hF0F0_F0F0, 32'h00FF_00FF};
    vb = '{32'h0000_0002, 32'h1111_1111, 32'h0000_0001, 32'h8000_0000,
           32'h0000_0001, 32'h5555_5555, 32'h0F0F_0F0F, 32'h00FF_00FF};
    vc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    es = '{32'h0000_0003, 32'h2345_6789, 32'h0000_0000, 32'h0000_0001,
           32'h0001_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h01FE_01FF};
    ec = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_sum", 64'(sum), 64'(0));
    check("reset_cout", 64'(cout), 64'(0));
`ifdef PIPELINED_ADDER_OVF_EN
    check("reset_ovf", 64'(ovf), 64'(0));
`endif
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", 64'(in_ready), 64'(1));

    single("add_small",   32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0);
    single("wrap_zero",   32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    single("wrap_ones",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    single("cross_slice", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    single("ovf_pos",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    single("ovf_neg",     32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);

    // Back-pressure: fill with the sink stalled, then drain while still streaming.
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      drive_beat(idx);
      #1;
      acc = in_valid && in_ready;
      @(negedge clk);
      if (acc) idx++;
    end
    #1;
    check("bp_accepts", 64'(idx), 64'(4));
    check("bp_in_ready_low", 64'(in_ready), 64'(0));
    check("bp_out_valid", 64'(out_valid), 64'(1));
    check("bp_head_sum", 64'(sum), 64'(es[0]));
    held = sum;
    @(negedge clk);
    check("bp_hold_sum", 64'(sum), 64'(held));
    check("bp_hold_valid", 64'(out_valid), 64'(1));

    out_ready = 1'b1;
    oidx = 0;
    for (int c = 0; c < 40 && oidx < 8; c++) begin
      drive_beat(idx);
      #1;
      acc = in_valid && in_ready;
      if (out_valid) begin
        check($sformatf("bp_sum_%0d", oidx), 64'(sum), 64'(es[oidx]));
        check($sformatf("bp_cout_%0d", oidx), 64'(cout), 64'(ec[oidx]));
        oidx++;
      end
      @(negedge clk);
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("bp_results", 64'(oidx), 64'(8));
    check("bp_all_sent", 64'(idx), 64'(8));
    #1;
    check("bp_no_duplicate", 64'(out_valid), 64'(0));

    // Reset with three beats in flight, the oldest already presented at the output.
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_beat(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_full_before_rst", 64'(out_valid), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_sum", 64'(sum), 64'(0));
    check("mid_rst_cout", 64'(cout), 64'(0));
    rst       = 1'b0;
    out_ready = 1'b1;
    stale     = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("mid_rst_no_stale", 64'(stale), 64'(0));

    single("after_rst", 32'h0000_0FFF, 32'h0000_0001, 1'b1, 32'h0000_1001, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
